rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, legal range 2..3, giving the per-requester queue depth in entries.
REQ-002 The block SHALL provide port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-004 The block SHALL provide ports wb0Valid (input, 1), wb0Ready (output, 1), wb0Addr (input, 5) and wb0Data (input, 32), forming writeback requester 0 (execute).
REQ-005 The block SHALL provide ports wb1Valid (input, 1), wb1Ready (output, 1), wb1Addr (input, 5) and wb1Data (input, 32), forming writeback requester 1 (load unit).
REQ-006 The block SHALL provide ports write (output, 1), addrWrite (output, 5) and dataWrite (output, 32), driving the register file's single write port, all registered.
REQ-007 The block SHALL provide port pending, output, 32 bits, where bit i is set while a write to register i is queued or being presented.

Function
REQ-008 A request SHALL be accepted in any cycle where wbNValid and wbNReady are both 1.
REQ-009 wbNReady SHALL equal (queue N count < DEPTH), derived from registered state only, with no dependence on valid or on a same-cycle pop.
REQ-010 An accepted request with Addr==0 SHALL be consumed and discarded: not enqueued, no tag used, never written.
REQ-011 Each enqueued entry SHALL carry a 3-bit sequence tag from a wrapping counter that advances by the number of entries enqueued that cycle.
REQ-012 When both requesters enqueue in the same cycle, port 1 SHALL receive the counter value and port 0 the counter value + 1, so port 1 is older.
REQ-013 Tag age SHALL be compared modulo 8; with at most 2*DEPTH+1 entries in flight this comparison is unambiguous.
REQ-014 Each cycle, at most one queue head SHALL be granted and popped.
REQ-015 With one non-empty queue, that queue's head SHALL be granted and the round-robin pointer SHALL be left unchanged.
REQ-016 With both heads valid and different addresses, the queue named by the round-robin pointer SHALL be granted, and the pointer SHALL then move to the other queue.
REQ-017 With both heads valid and equal addresses, the older tag SHALL be granted and the pointer SHALL be left unchanged, preserving program-order write order.
REQ-018 The grant in cycle M SHALL assert write=1 with that entry's addrWrite and dataWrite in cycle M+1.
REQ-019 The uncontended latency SHALL be: request accepted in cycle N, write asserted in cycle N+2.
REQ-020 In a cycle with no grant, write SHALL be 0 in the following cycle, and addrWrite and dataWrite SHALL hold their previous values.
REQ-021 A push and a pop on the same queue in the same cycle SHALL be legal; the count is unchanged and FIFO order is kept.
REQ-022 pending[i] SHALL be 1 iff a valid queue entry or the output register (with write=1) holds address i.
REQ-023 pending SHALL be computed combinationally from state, and pending[0] SHALL be constantly 0.
REQ-024 Accepted non-x0 requests SHALL never be lost or duplicated: the total number of write pulses equals the number of accepted non-x0 requests.

Reset
REQ-025 When rst=1 at a clock edge, both queues SHALL empty, the tag counter SHALL clear to 0 and the round-robin pointer SHALL be set to port 0.
REQ-026 On that same reset edge, write, addrWrite and dataWrite SHALL clear to 0, which also makes pending=0.
REQ-027 Reset asserted mid-operation SHALL drop all queued entries, and write SHALL be 0 in the cycle after the reset edge.
REQ-028 wbNReady SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-029 A shared package SHALL hold XLEN=32, REG_ADDR_W=5, NUM_REGS=32, TAG_W=3 and the writeback entry type {addr, data, tag}.
REQ-030 The per-requester queue SHALL be one sub-module, wb_fifo (parameter DEPTH), instantiated twice and exposing head entry, head-valid, count, push and pop.
REQ-031 Arbitration, tag generation, pending decode and the output register SHALL live in rf_wb_arbiter.

Verification
REQ-032 Single write: port 0, addr 5, data 0xDEADBEEF accepted in cycle 1 -> write=1, addrWrite=5, dataWrite=0xDEADBEEF in cycle 3; pending[5]=1 in cycles 2-3 and 0 in cycle 4.
REQ-033 x0 discard: port 1, addr 0, data 0x1234 accepted -> wb1Ready stays 1, write is never asserted, pending stays 0.
REQ-034 Different-address contention: immediately after reset, port 0 addr 3 and port 1 addr 4 are accepted in the same cycle -> addr 3 is written first, then addr 4 in the next cycle.
REQ-035 Same-address ordering: port 0 (addr 7, data 0xA) and port 1 (addr 7, data 0xB) are accepted in the same cycle -> 0xB is written first, then 0xA; final x7 = 0xA.
REQ-036 Backpressure: both ports hold valid high with new data for 10 cycles -> ready drops when count=2, grants alternate between ports, and write pulses equal accepted requests with data intact.
REQ-037 Reset mid-operation: fill both queues, then pulse rst for 1 cycle -> write=0 and pending=0 in the next cycle, both readies=1, and no stale write ever appears.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: widths, the queued entry and tag-age helper.
// Pure definitions; no timing or flow-control behaviour lives here.
package rf_wb_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int TAG_W      = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [TAG_W-1:0]      tag_t;

    typedef struct packed {
        reg_addr_t       addr;
        logic [XLEN-1:0] data;
        tag_t            tag;
    } wb_entry_t;

    // Age is the distance behind the next tag to be issued; fewer than 8 entries are ever live.
    function automatic logic tag_older(input tag_t a, input tag_t b, input tag_t next_tag);
        tag_t age_a;
        tag_t age_b;
        age_a = next_tag - a;
        age_b = next_tag - b;
        return age_a > age_b;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-requester writeback queue: push visible at the head one cycle later, same-cycle push+pop legal.
// No internal backpressure; the owner must not push when count == DEPTH or pop when empty.
module wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    output wb_entry_t             head,
    output logic                  head_vld,
    output logic [CNT_W-1:0]      count,
    output reg_addr_t [DEPTH-1:0] entry_addr,
    output logic [DEPTH-1:0]      entry_vld
);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            entry_vld <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr]       <= push_entry;
                entry_vld[wr_ptr] <= 1'b1;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            // Push and pop never target the same slot: that needs an empty pop or a full push.
            if (pop) begin
                entry_vld[rd_ptr] <= 1'b0;
                rd_ptr            <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head     = mem[rd_ptr];
        head_vld = (count != '0);
        for (int i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem[i].addr;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges two writeback streams onto one register-file write port; accept->write is 2 cycles uncontended.
// Each requester sees ready while its queue has room; same-register writes leave in program order.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb0Valid,
    output logic                  wb0Ready,
    input  logic [REG_ADDR_W-1:0] wb0Addr,
    input  logic [XLEN-1:0]       wb0Data,
    input  logic                  wb1Valid,
    output logic                  wb1Ready,
    input  logic [REG_ADDR_W-1:0] wb1Addr,
    input  logic [XLEN-1:0]       wb1Data,
    output logic                  write,
    output logic [REG_ADDR_W-1:0] addrWrite,
    output logic [XLEN-1:0]       dataWrite,
    output logic [NUM_REGS-1:0]   pending
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [1:0]                   rdy;
    logic [1:0]                   enq;
    logic [1:0]                   pop;
    logic [1:0]                   head_vld;
    wb_entry_t [1:0]              head;
    wb_entry_t [1:0]              push_entry;
    logic [1:0][CNT_W-1:0]        count;
    reg_addr_t [1:0][DEPTH-1:0]   entry_addr;
    logic [1:0][DEPTH-1:0]        entry_vld;
    tag_t                         tag_cnt;
    logic                         rr_ptr;
    logic                         rr_next;

    always_comb begin
        rdy[0]   = (count[0] < CNT_W'(DEPTH));
        rdy[1]   = (count[1] < CNT_W'(DEPTH));
        wb0Ready = rdy[0];
        wb1Ready = rdy[1];
        // Writes to x0 are swallowed at acceptance and never occupy a slot or a tag.
        enq[0]   = wb0Valid && rdy[0] && (wb0Addr != '0);
        enq[1]   = wb1Valid && rdy[1] && (wb1Addr != '0);
        push_entry[1] = '{addr: wb1Addr, data: wb1Data, tag: tag_cnt};
        push_entry[0] = '{addr: wb0Addr, data: wb0Data, tag: tag_cnt + tag_t'(enq[1])};
    end

    for (genvar n = 0; n < 2; n++) begin : g_queue
        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (enq[n]),
            .push_entry (push_entry[n]),
            .pop        (pop[n]),
            .head       (head[n]),
            .head_vld   (head_vld[n]),
            .count      (count[n]),
            .entry_addr (entry_addr[n]),
            .entry_vld  (entry_vld[n])
        );
    end

    always_comb begin
        pop     = head_vld;
        rr_next = rr_ptr;
        if (head_vld[0] && head_vld[1]) begin
            if (head[0].addr == head[1].addr) begin
                pop = tag_older(head[1].tag, head[0].tag, tag_cnt) ? 2'b10 : 2'b01;
            end else begin
                pop     = rr_ptr ? 2'b10 : 2'b01;
                rr_next = ~rr_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write     <= 1'b0;
            addrWrite <= '0;
            dataWrite <= '0;
            rr_ptr    <= 1'b0;
            tag_cnt   <= '0;
        end else begin
            write   <= |pop;
            rr_ptr  <= rr_next;
            tag_cnt <= tag_cnt + tag_t'(enq[0]) + tag_t'(enq[1]);
            if (pop[1]) begin
                addrWrite <= head[1].addr;
                dataWrite <= head[1].data;
            end else if (pop[0]) begin
                addrWrite <= head[0].addr;
                dataWrite <= head[0].data;
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_vld[n][i]) begin
                    pending[entry_addr[n][i]] = 1'b1;
                end
            end
        end
        if (write) begin
            pending[addrWrite] = 1'b1;
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table, directed corner sequences and random traffic vs a queue model.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb0Valid, wb0Ready, wb1Valid, wb1Ready;
    logic [4:0]  wb0Addr, wb1Addr, addrWrite;
    logic [31:0] wb0Data, wb1Data, dataWrite, pending;
    logic        write;

    rf_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb0Valid  (wb0Valid),
        .wb0Ready  (wb0Ready),
        .wb0Addr   (wb0Addr),
        .wb0Data   (wb0Data),
        .wb1Valid  (wb1Valid),
        .wb1Ready  (wb1Ready),
        .wb1Addr   (wb1Addr),
        .wb1Data   (wb1Data),
        .write     (write),
        .addrWrite (addrWrite),
        .dataWrite (dataWrite),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one queue per requester in arrival order, global sequence number for age.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          seq;
    } m_ent_t;

    m_ent_t      q0[$];
    m_ent_t      q1[$];
    int          seq_next = 0;
    bit          rr = 1'b0;
    bit          e_write = 1'b0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    int          acc_cnt = 0;
    int          wr_cnt = 0;
    int          rdy_low_seen = 0;

    typedef struct {
        bit          v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        bit          v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        bit          r;
        bit          w;
        logic [4:0]  aw;
        logic [31:0] dw;
        logic [31:0] pend;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = '0;
        foreach (q0[i]) p[q0[i].addr] = 1'b1;
        foreach (q1[i]) p[q1[i].addr] = 1'b1;
        if (e_write) p[e_addr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    // Called just after a rising edge; drives one cycle of inputs and returns just after the next edge.
    task automatic cycle(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1, input bit r);
        bit     r0, r1;
        int     g;
        m_ent_t e;
        rst = r; wb0Valid = v0; wb0Addr = a0; wb0Data = d0;
        wb1Valid = v1; wb1Addr = a1; wb1Data = d1;
        #2;
        r0 = (q0.size() < DEPTH);
        r1 = (q1.size() < DEPTH);
        check("wb0Ready", {31'b0, wb0Ready}, {31'b0, r0});
        check("wb1Ready", {31'b0, wb1Ready}, {31'b0, r1});
        if (!r0 || !r1) rdy_low_seen++;
        if (r) begin
            q0.delete(); q1.delete();
            rr = 1'b0; e_write = 1'b0; e_addr = '0; e_data = '0;
            acc_cnt = 0; wr_cnt = 0;
        end else begin
            g = -1;
            if (q0.size() > 0 && q1.size() > 0) begin
                if (q0[0].addr == q1[0].addr) g = (q0[0].seq < q1[0].seq) ? 0 : 1;
                else begin
                    g = rr ? 1 : 0;
                    rr = !rr;
                end
            end else if (q0.size() > 0) g = 0;
            else if (q1.size() > 0) g = 1;
            e_write = (g >= 0);
            if (g == 0) begin
                e = q0.pop_front(); e_addr = e.addr; e_data = e.data;
            end else if (g == 1) begin
                e = q1.pop_front(); e_addr = e.addr; e_data = e.data;
            end
            if (v1 && r1 && a1 != 5'd0) begin
                q1.push_back('{addr: a1, data: d1, seq: seq_next});
                seq_next++; acc_cnt++;
            end
            if (v0 && r0 && a0 != 5'd0) begin
                q0.push_back('{addr: a0, data: d0, seq: seq_next});
                seq_next++; acc_cnt++;
            end
        end
        @(posedge clk);
        #1;
        check("write", {31'b0, write}, {31'b0, e_write});
        check("addrWrite", {27'b0, addrWrite}, {27'b0, e_addr});
        check("dataWrite", dataWrite, e_data);
        check("pending", pending, model_pending());
        if (write === 1'b1) wr_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0, 0, 0,            0, 0, 0,        1, 0, 0, 0,            32'h0};
        vecs[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0, 0,            32'h20};
        vecs[2]  = '{0, 0, 0,            0, 0, 0,        0, 1, 5, 32'hDEADBEEF, 32'h20};
        vecs[3]  = '{0, 0, 0,            0, 0, 0,        0, 0, 5, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{0, 0, 0,            1, 0, 32'h1234, 0, 0, 5, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{0, 0, 0,            0, 0, 0,        0, 0, 5, 32'hDEADBEEF, 32'h0};
        vecs[6]  = '{0, 0, 0,            0, 0, 0,        1, 0, 0, 0,            32'h0};
        vecs[7]  = '{1, 3, 32'h33,       1, 4, 32'h44,   0, 0, 0, 0,            32'h18};
        vecs[8]  = '{0, 0, 0,            0, 0, 0,        0, 1, 3, 32'h33,       32'h18};
        vecs[9]  = '{0, 0, 0,            0, 0, 0,        0, 1, 4, 32'h44,       32'h10};
        vecs[10] = '{0, 0, 0,            0, 0, 0,        0, 0, 4, 32'h44,       32'h0};
        vecs[11] = '{1, 7, 32'hA,        1, 7, 32'hB,    0, 0, 4, 32'h44,       32'h80};
        vecs[12] = '{0, 0, 0,            0, 0, 0,        0, 1, 7, 32'hB,        32'h80};
        vecs[13] = '{0, 0, 0,            0, 0, 0,        0, 1, 7, 32'hA,        32'h80};
        vecs[14] = '{0, 0, 0,            0, 0, 0,        0, 0, 7, 32'hA,        32'h0};

        rst = 1'b1; wb0Valid = 0; wb0Addr = 0; wb0Data = 0;
        wb1Valid = 0; wb1Addr = 0; wb1Data = 0;
        @(posedge clk);
        #1;
        check("reset write", {31'b0, write}, 32'd0);
        check("reset addrWrite", {27'b0, addrWrite}, 32'd0);
        check("reset dataWrite", dataWrite, 32'd0);
        check("reset pending", pending, 32'd0);
        check("reset wb0Ready", {31'b0, wb0Ready}, 32'd1);
        check("reset wb1Ready", {31'b0, wb1Ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            cycle(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].r);
            check($sformatf("vec%0d write", i), {31'b0, write}, {31'b0, vecs[i].w});
            check($sformatf("vec%0d addrWrite", i), {27'b0, addrWrite}, {27'b0, vecs[i].aw});
            check($sformatf("vec%0d dataWrite", i), dataWrite, vecs[i].dw);
            check($sformatf("vec%0d pending", i), pending, vecs[i].pend);
        end

        // Sustained two-port pressure: readies must drop and nothing may be lost.
        acc_cnt = 0; wr_cnt = 0; rdy_low_seen = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 5'd10, 32'h1000 + i, 1, 5'd20, 32'h2000 + i, 0);
        end
        idle(8);
        check("backpressure ready drop", {31'b0, rdy_low_seen > 0}, 32'd1);
        check("backpressure conservation", wr_cnt, acc_cnt);

        // Fill both queues, then reset mid-flight.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 5'd12, 32'h3000 + i, 1, 5'd13, 32'h4000 + i, 0);
        end
        cycle(0, 0, 0, 0, 0, 0, 1);
        check("midreset write", {31'b0, write}, 32'd0);
        check("midreset pending", pending, 32'd0);
        check("midreset wb0Ready", {31'b0, wb0Ready}, 32'd1);
        check("midreset wb1Ready", {31'b0, wb1Ready}, 32'd1);
        idle(6);
        check("midreset no stale write", wr_cnt, 32'd0);

        // Random traffic on a narrow register range to force same-address collisions.
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 199) == 0);
        end
        idle(10);
        check("random conservation", wr_cnt, acc_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
